nios2_oci_dct_packer: RTL and testbench

- Sequences the OCI data-compression-trace (DCT) buffer: packs 2-bit trace atoms into a 30-bit dct_buffer (15 slots) with a 4-bit dct_count.
- Hands completed words to the downstream trace FIFO over a valid/ready handshake.
- Flushes a partial word on test_ending and then raises test_has_ended.
- Sits between the Nios II trace-atom source and the OCI trace FIFO. Drives the dct_buffer/dct_count/test_ending/test_has_ended signals consumed by the OCI test bench.

---
 rtl/nios2_oci_dct_pkg.sv | 23 ++
 rtl/nios2_oci_dct_outreg.sv | 31 +++
 rtl/nios2_oci_dct_packer.sv | 111 +++++++++++
 tb/tb_nios2_oci_dct_packer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_oci_dct_pkg.sv
// Shared widths, FSM state type and trace-atom codes for the OCI DCT packer.
package nios2_oci_dct_pkg;

    localparam int ATOM_W = 2;
    localparam int SLOTS  = 15;
    localparam int CNT_W  = 4;
    localparam int BUF_W  = ATOM_W * SLOTS;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(SLOTS);

    typedef enum logic [1:0] {
        ACCUM,
        FLUSH,
        DRAIN,
        ENDED
    } dct_state_e;

    localparam logic [ATOM_W-1:0] ATOM_NOP       = 2'b00;
    localparam logic [ATOM_W-1:0] ATOM_TAKEN     = 2'b01;
    localparam logic [ATOM_W-1:0] ATOM_NOT_TAKEN = 2'b10;
    localparam logic [ATOM_W-1:0] ATOM_MARKER    = 2'b11;

endpackage

// File: rtl/nios2_oci_dct_outreg.sv
// Single-entry valid/ready output register for packed DCT words.
module nios2_oci_dct_outreg
    import nios2_oci_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BUF_W-1:0] load_data,
    input  logic [CNT_W-1:0] load_count,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [BUF_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    // A load may coincide with the drain of the previous word; the load wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_count <= load_count;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit DCT words and drains them at end of test.
// Optional feature macro: NIOS2_OCI_DCT_OVERFLOW_CNT_EN (drop-and-count instead of backpressure).
module nios2_oci_dct_packer
    import nios2_oci_dct_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              atom_valid,
    input  logic [ATOM_W-1:0] atom,
    output logic              atom_ready,
    input  logic              flush_req,
    input  logic              test_ending,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BUF_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              test_has_ended
`ifdef NIOS2_OCI_DCT_OVERFLOW_CNT_EN
    ,
    output logic [15:0]       overflow_cnt
`endif
);

    dct_state_e state;
    logic       flush_pending;
    logic       full;
    logic       out_free;
    logic       accept;
    logic       move;
`ifdef NIOS2_OCI_DCT_OVERFLOW_CNT_EN
    logic       drop;
`endif

    // The output register is free when empty or being drained this very cycle.
    always_comb begin
        full     = (dct_count == FULL_COUNT);
        out_free = !out_valid || out_ready;
`ifdef NIOS2_OCI_DCT_OVERFLOW_CNT_EN
        atom_ready = (state == ACCUM);
        drop       = atom_valid && atom_ready && full && !out_free;
`else
        atom_ready = (state == ACCUM) && !(full && out_valid && !out_ready);
`endif
        accept = atom_valid && atom_ready && !(full && !out_free);
        move   = 1'b0;
        case (state)
            ACCUM:   move = out_free && (full || ((flush_req || flush_pending) && dct_count != '0));
            FLUSH:   move = out_free && (dct_count != '0);
            default: move = 1'b0;
        endcase
    end

    // Packing buffer and drain sequencer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ACCUM;
            dct_buffer     <= '0;
            dct_count      <= '0;
            flush_pending  <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            if (move) begin
                dct_buffer <= accept ? BUF_W'(atom) : '0;
                dct_count  <= accept ? CNT_W'(1) : '0;
            end else if (accept) begin
                dct_buffer <= {dct_buffer[BUF_W-ATOM_W-1:0], atom};
                dct_count  <= dct_count + CNT_W'(1);
            end

            if (move)
                flush_pending <= 1'b0;
            else if (state == ACCUM && flush_req && dct_count != '0)
                flush_pending <= 1'b1;

            case (state)
                ACCUM: if (test_ending) state <= FLUSH;
                FLUSH: if (dct_count == '0 || move) state <= DRAIN;
                DRAIN: if (!out_valid) begin
                    state          <= ENDED;
                    test_has_ended <= 1'b1;
                end
                default: test_has_ended <= 1'b1;
            endcase
        end
    end

`ifdef NIOS2_OCI_DCT_OVERFLOW_CNT_EN
    // Saturating count of atoms lost while a full word was stuck behind backpressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow_cnt <= '0;
        else if (drop && state != ENDED && overflow_cnt != 16'hFFFF)
            overflow_cnt <= overflow_cnt + 16'd1;
    end
`endif

    nios2_oci_dct_outreg u_outreg (
        .clk        (clk),
        .reset      (reset),
        .load       (move),
        .load_data  (dct_buffer),
        .load_count (dct_count),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_count  (out_count)
    );

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// Directed self-checking bench for nios2_oci_dct_packer.
module tb_nios2_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        atom_valid;
    logic [1:0]  atom;
    logic        atom_ready;
    logic        flush_req;
    logic        test_ending;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] out_data;
    logic [3:0]  out_count;
    logic        test_has_ended;
`ifdef NIOS2_OCI_DCT_OVERFLOW_CNT_EN
    logic [15:0] overflow_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nios2_oci_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .atom_valid     (atom_valid),
        .atom           (atom),
        .atom_ready     (atom_ready),
        .flush_req      (flush_req),
        .test_ending    (test_ending),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_count      (out_count),
        .test_has_ended (test_has_ended)
`ifdef NIOS2_OCI_DCT_OVERFLOW_CNT_EN
        ,
        .overflow_cnt   (overflow_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] atom_of(input int i);
        atom_of = 2'((i * 3 + 1) % 4);
    endfunction

    // Oldest atom ends up in the top slot, newest in [1:0].
    function automatic logic [29:0] pack_word(input int first);
        logic [29:0] w = '0;
        for (int j = 0; j < 15; j++) w = {w[27:0], atom_of(first + j)};
        pack_word = w;
    endfunction

    task automatic do_reset();
        reset = 1'b1; atom_valid = 1'b0; atom = 2'b00; flush_req = 1'b0;
        test_ending = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic push_atoms(input int n, input logic [1:0] a);
        atom_valid = 1'b1; atom = a;
        for (int i = 0; i < n; i++) tick();
        atom_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dct_buffer !== 30'h0 || dct_count !== 4'd0) begin errors++;
            $display("[TB] FAIL reset_buffer: got %h/%0d expected 0/0", dct_buffer, dct_count); end
        checks++; if (out_valid !== 1'b0 || out_data !== 30'h0 || out_count !== 4'd0) begin errors++;
            $display("[TB] FAIL reset_out: got v=%b d=%h c=%0d expected 0", out_valid, out_data, out_count); end
        checks++; if (test_has_ended !== 1'b0 || atom_ready !== 1'b1) begin errors++;
            $display("[TB] FAIL reset_flags: got ended=%b ready=%b expected 0/1", test_has_ended, atom_ready); end
    endtask

    task automatic test_full_word();
        do_reset();
        out_ready = 1'b1;
        push_atoms(1, 2'b01);
        checks++; if (dct_count !== 4'd1 || dct_buffer !== 30'h1) begin errors++;
            $display("[TB] FAIL first_atom: got %0d/%h expected 1/1", dct_count, dct_buffer); end
        push_atoms(14, 2'b01);
        checks++; if (dct_count !== 4'd15 || dct_buffer !== 30'h15555555 || out_valid !== 1'b0) begin errors++;
            $display("[TB] FAIL full_buffer: got %0d/%h v=%b expected 15/15555555 v=0", dct_count, dct_buffer, out_valid); end
        push_atoms(1, 2'b01);
        checks++; if (out_valid !== 1'b1 || out_data !== 30'h15555555 || out_count !== 4'd15) begin errors++;
            $display("[TB] FAIL full_word_out: got v=%b d=%h c=%0d expected 1/15555555/15", out_valid, out_data, out_count); end
        checks++; if (dct_count !== 4'd1 || dct_buffer !== 30'h1) begin errors++;
            $display("[TB] FAIL same_cycle_accept: got %0d/%h expected 1/1", dct_count, dct_buffer); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("[TB] FAIL full_word_drop: got v=%b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int cyc = 0;
        logic acc;
        do_reset();
        out_ready = 1'b0;
        while (n < 30 && cyc < 200) begin
            atom_valid = 1'b1; atom = atom_of(n);
            acc = atom_ready;
            tick();
            if (acc) n++;
            cyc++;
        end
        atom_valid = 1'b0;
        checks++; if (n != 30) begin errors++;
            $display("[TB] FAIL bp_timeout: got %0d atoms expected 30", n); end
        checks++; if (dct_count !== 4'd15 || atom_ready !== 1'b0 || dct_buffer !== pack_word(15)) begin errors++;
            $display("[TB] FAIL bp_stall: got cnt=%0d ready=%b buf=%h expected 15/0/%h", dct_count, atom_ready, dct_buffer, pack_word(15)); end
        tick(); tick(); tick();
        checks++; if (out_valid !== 1'b1 || out_data !== pack_word(0) || out_count !== 4'd15) begin errors++;
            $display("[TB] FAIL bp_hold: got v=%b d=%h c=%0d expected 1/%h/15", out_valid, out_data, out_count, pack_word(0)); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== pack_word(15) || out_count !== 4'd15 || dct_count !== 4'd0) begin errors++;
            $display("[TB] FAIL bp_second: got v=%b d=%h c=%0d cnt=%0d expected 1/%h/15/0", out_valid, out_data, out_count, dct_count, pack_word(15)); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("[TB] FAIL bp_empty: got v=%b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        push_atoms(5, 2'b11);
        flush_req = 1'b1; tick(); flush_req = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_count !== 4'd5 || out_data !== 30'h000003FF || dct_count !== 4'd0) begin errors++;
            $display("[TB] FAIL flush_partial: got v=%b c=%0d d=%h cnt=%0d expected 1/5/3ff/0", out_valid, out_count, out_data, dct_count); end
        push_atoms(3, 2'b10);
        flush_req = 1'b1; tick(); flush_req = 1'b0;
        checks++; if (out_count !== 4'd5 || out_data !== 30'h3FF || dct_count !== 4'd3) begin errors++;
            $display("[TB] FAIL flush_blocked: got c=%0d d=%h cnt=%0d expected 5/3ff/3", out_count, out_data, dct_count); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_count !== 4'd3 || out_data !== 30'h2A || dct_count !== 4'd0) begin errors++;
            $display("[TB] FAIL flush_pending: got v=%b c=%0d d=%h cnt=%0d expected 1/3/2a/0", out_valid, out_count, out_data, dct_count); end
        tick();
        flush_req = 1'b1; tick(); flush_req = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("[TB] FAIL flush_empty: got v=%b expected 0", out_valid); end
    endtask

    task automatic test_end_of_test();
        int waited = 0;
        do_reset();
        out_ready = 1'b1;
        push_atoms(7, 2'b01);
        test_ending = 1'b1;
        tick();
        checks++; if (atom_ready !== 1'b0) begin errors++;
            $display("[TB] FAIL end_ready: got %b expected 0", atom_ready); end
        tick();
        test_ending = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_count !== 4'd7 || out_data !== 30'h1555) begin errors++;
            $display("[TB] FAIL end_partial: got v=%b c=%0d d=%h expected 1/7/1555", out_valid, out_count, out_data); end
        while (test_has_ended !== 1'b1 && waited < 10) begin tick(); waited++; end
        checks++; if (test_has_ended !== 1'b1) begin errors++;
            $display("[TB] FAIL end_timeout: got ended=%b expected 1", test_has_ended); end
        atom_valid = 1'b1; atom = 2'b01;
        tick(); tick(); tick();
        atom_valid = 1'b0;
        checks++; if (test_has_ended !== 1'b1 || atom_ready !== 1'b0 || dct_count !== 4'd0 || out_valid !== 1'b0) begin errors++;
            $display("[TB] FAIL end_sticky: got ended=%b ready=%b cnt=%0d v=%b expected 1/0/0/0", test_has_ended, atom_ready, dct_count, out_valid); end
    endtask

    task automatic test_simultaneous_end();
        int seen = 0;
        do_reset();
        out_ready = 1'b1;
        push_atoms(15, 2'b10);
        flush_req = 1'b1; test_ending = 1'b1;
        tick();
        flush_req = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_count !== 4'd15 || out_data !== 30'h2AAAAAAA || dct_count !== 4'd0) begin errors++;
            $display("[TB] FAIL simul_move: got v=%b c=%0d d=%h cnt=%0d expected 1/15/2aaaaaaa/0", out_valid, out_count, out_data, dct_count); end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        test_ending = 1'b0;
        checks++; if (seen != 0 || test_has_ended !== 1'b1) begin errors++;
            $display("[TB] FAIL simul_single: got extra=%0d ended=%b expected 0/1", seen, test_has_ended); end
    endtask

    task automatic test_reset_midway();
        do_reset();
        out_ready = 1'b0;
        push_atoms(24, 2'b01);
        checks++; if (dct_count !== 4'd9 || out_valid !== 1'b1) begin errors++;
            $display("[TB] FAIL mid_setup: got cnt=%0d v=%b expected 9/1", dct_count, out_valid); end
        #1 reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 30'h0 || out_count !== 4'd0 || dct_count !== 4'd0 || dct_buffer !== 30'h0) begin errors++;
            $display("[TB] FAIL mid_async: got v=%b d=%h c=%0d cnt=%0d buf=%h expected all 0", out_valid, out_data, out_count, dct_count, dct_buffer); end
        tick();
        reset = 1'b0;
        tick();
        push_atoms(2, 2'b01);
        checks++; if (dct_count !== 4'd2 || dct_buffer !== 30'h5 || out_valid !== 1'b0) begin errors++;
            $display("[TB] FAIL mid_resume: got cnt=%0d buf=%h v=%b expected 2/5/0", dct_count, dct_buffer, out_valid); end
    endtask

`ifdef NIOS2_OCI_DCT_OVERFLOW_CNT_EN
    task automatic test_overflow();
        do_reset();
        out_ready = 1'b0;
        push_atoms(40, 2'b01);
        checks++; if (overflow_cnt !== 16'd10 || dct_count !== 4'd15 || out_valid !== 1'b1) begin errors++;
            $display("[TB] FAIL overflow: got ovf=%0d cnt=%0d v=%b expected 10/15/1", overflow_cnt, dct_count, out_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_full_word();
        test_back_to_back();
        test_flush();
        test_end_of_test();
        test_simultaneous_end();
        test_reset_midway();
`ifdef NIOS2_OCI_DCT_OVERFLOW_CNT_EN
        test_overflow();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
